// File: rtl/flit_depacketizer.sv
// rtl/flit_depacketizer.sv - reassembles one no-VC flit packet at a time and holds it until acknowledged
// Head fields and body words are latched here; protocol violations pulse err_unexpected.
module flit_depacketizer #(
  parameter int BUFFER_SIZE = 8,
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int HP_W        = 12,
  parameter int DATA_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [X_W-1:0]                   local_x,
  input  logic [Y_W-1:0]                   local_y,
  input  logic                             flit_valid,
  output logic                             flit_ready,
  input  logic [1:0]                       flit_label,
  input  logic [DATA_W-1:0]                flit_payload,
  output logic                             pkt_valid,
  input  logic                             pkt_ack,
  output logic [X_W-1:0]                   pkt_x,
  output logic [Y_W-1:0]                   pkt_y,
  output logic [HP_W-1:0]                  pkt_head,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] pkt_len,
  output logic                             pkt_misroute,
  output logic                             pkt_trunc,
  input  logic [$clog2(BUFFER_SIZE)-1:0]   pkt_rd_idx,
  output logic [DATA_W-1:0]                pkt_rd_data,
  output logic                             err_unexpected
);

  localparam int LW = $clog2(BUFFER_SIZE+1);
  localparam int IW = $clog2(BUFFER_SIZE);
  localparam logic [LW-1:0] FULL_LEN = LW'(BUFFER_SIZE);

  localparam logic [1:0] LBL_HEAD     = 2'd0;
  localparam logic [1:0] LBL_BODY     = 2'd1;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t state, state_nxt;
  logic   err_nxt;
  logic   accept;
  logic   is_head;
  logic   full;

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [HP_W-1:0]   head_q;
  logic [LW-1:0]     len_q;
  logic              mis_q;
  logic              trunc_q;
  logic              err_q;
  logic [DATA_W-1:0] buffer [BUFFER_SIZE];

  logic [X_W-1:0]  in_x;
  logic [Y_W-1:0]  in_y;
  logic [HP_W-1:0] in_head;

  assign in_x    = flit_payload[X_W-1:0];
  assign in_y    = flit_payload[X_W+Y_W-1:X_W];
  assign in_head = flit_payload[X_W+Y_W+HP_W-1:X_W+Y_W];

  assign flit_ready = (state != HOLD) && !rst;
  assign accept     = flit_valid && flit_ready;
  assign is_head    = (flit_label == LBL_HEAD) || (flit_label == LBL_HEADTAIL);
  assign full       = (len_q == FULL_LEN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (flit_label)
            LBL_HEAD:     state_nxt = COLLECT;
            LBL_HEADTAIL: state_nxt = HOLD;
            default:      err_nxt   = 1'b1;
          endcase
        end
      end
      COLLECT: begin
        if (accept) begin
          case (flit_label)
            LBL_HEAD:     err_nxt = 1'b1;
            LBL_HEADTAIL: begin
              err_nxt   = 1'b1;
              state_nxt = HOLD;
            end
            LBL_TAIL:     state_nxt = HOLD;
            default:      state_nxt = COLLECT;
          endcase
        end
      end
      HOLD:    if (pkt_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Head flits restart the packet from either IDLE or COLLECT; words only count while collecting.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      head_q  <= '0;
      len_q   <= '0;
      mis_q   <= 1'b0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (accept && is_head) begin
        x_q     <= in_x;
        y_q     <= in_y;
        head_q  <= in_head;
        mis_q   <= (in_x != local_x) || (in_y != local_y);
        len_q   <= '0;
        trunc_q <= 1'b0;
      end else if (accept && state == COLLECT) begin
        if (full) trunc_q <= 1'b1;
        else      len_q   <= len_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !is_head && state == COLLECT && !full)
      buffer[len_q[IW-1:0]] <= flit_payload;
  end

  assign pkt_valid      = (state == HOLD);
  assign pkt_x          = x_q;
  assign pkt_y          = y_q;
  assign pkt_head       = head_q;
  assign pkt_len        = len_q;
  assign pkt_misroute   = mis_q;
  assign pkt_trunc      = trunc_q;
  assign pkt_rd_data    = buffer[pkt_rd_idx];
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_flit_depacketizer.sv
// tb/tb_flit_depacketizer.sv - randomized self-checking bench for flit_depacketizer
// A queue-based packet model tracks the expected reassembled packet and error count.
module tb_flit_depacketizer;

  localparam int BUFFER_SIZE = 8;
  localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  local_x, local_y;
  logic        flit_valid;
  logic        flit_ready;
  logic [1:0]  flit_label;
  logic [15:0] flit_payload;
  logic        pkt_valid;
  logic        pkt_ack;
  logic [1:0]  pkt_x, pkt_y;
  logic [11:0] pkt_head;
  logic [3:0]  pkt_len;
  logic        pkt_misroute, pkt_trunc;
  logic [2:0]  pkt_rd_idx;
  logic [15:0] pkt_rd_data;
  logic        err_unexpected;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;

  // Model state
  bit          m_open;
  bit          m_done;
  logic [1:0]  m_x, m_y;
  logic [11:0] m_head;
  bit          m_mis;
  bit          m_trunc;
  logic [15:0] m_words[$];
  int          m_err = 0;

  flit_depacketizer #(.BUFFER_SIZE(BUFFER_SIZE)) dut (
    .clk(clk), .rst(rst), .local_x(local_x), .local_y(local_y),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_label(flit_label),
    .flit_payload(flit_payload), .pkt_valid(pkt_valid), .pkt_ack(pkt_ack),
    .pkt_x(pkt_x), .pkt_y(pkt_y), .pkt_head(pkt_head), .pkt_len(pkt_len),
    .pkt_misroute(pkt_misroute), .pkt_trunc(pkt_trunc), .pkt_rd_idx(pkt_rd_idx),
    .pkt_rd_data(pkt_rd_data), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_unexpected === 1'b1) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk_head(logic [1:0] x, logic [1:0] y, logic [11:0] h);
    return {h, y, x};
  endfunction

  task automatic model_apply(logic [1:0] lbl, logic [15:0] pl);
    if (lbl == HEAD || lbl == HEADTAIL) begin
      if (m_open) m_err++;
      m_x = pl[1:0];
      m_y = pl[3:2];
      m_head = pl[15:4];
      m_mis = (m_x != local_x) || (m_y != local_y);
      m_trunc = 0;
      m_words.delete();
      m_open = (lbl == HEAD);
      m_done = (lbl == HEADTAIL);
    end else if (!m_open) begin
      m_err++;
    end else begin
      if (m_words.size() < BUFFER_SIZE) m_words.push_back(pl);
      else m_trunc = 1;
      if (lbl == TAIL) begin
        m_open = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic idle(int n);
    flit_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_flit(logic [1:0] lbl, logic [15:0] pl);
    int cyc = 0;
    flit_valid = 1;
    flit_label = lbl;
    flit_payload = pl;
    while (flit_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (flit_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: flit_ready=%b required 1", flit_ready);
    end else begin
      model_apply(lbl, pl);
    end
    @(negedge clk);
    flit_valid = 0;
  endtask

  task automatic receive_packet(string name);
    int cyc = 0;
    while (pkt_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (pkt_valid !== 1'b1 || !m_done) begin
      miscompares++;
      $display("FAIL %s pkt_valid: got %b required 1 (model done=%0d)", name, pkt_valid, m_done);
    end
    vectors++;
    if (pkt_x !== m_x || pkt_y !== m_y || pkt_head !== m_head) begin
      miscompares++;
      $display("FAIL %s head: got x=%0d y=%0d h=%h required x=%0d y=%0d h=%h",
               name, pkt_x, pkt_y, pkt_head, m_x, m_y, m_head);
    end
    vectors++;
    if (pkt_len !== 4'(m_words.size())) begin
      miscompares++;
      $display("FAIL %s len: got %0d required %0d", name, pkt_len, m_words.size());
    end
    vectors++;
    if (pkt_misroute !== m_mis || pkt_trunc !== m_trunc) begin
      miscompares++;
      $display("FAIL %s flags: got mis=%b trunc=%b required mis=%b trunc=%b",
               name, pkt_misroute, pkt_trunc, m_mis, m_trunc);
    end
    for (int i = 0; i < m_words.size(); i++) begin
      pkt_rd_idx = 3'(i);
      #1;
      vectors++;
      if (pkt_rd_data !== m_words[i]) begin
        miscompares++;
        $display("FAIL %s word%0d: got %h required %h", name, i, pkt_rd_data, m_words[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (flit_ready !== 1'b0 || pkt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s hold: got ready=%b valid=%b required ready=0 valid=1", name, flit_ready, pkt_valid);
    end
    pkt_ack = 1;
    @(negedge clk);
    pkt_ack = 0;
    m_done = 0;
    vectors++;
    if (pkt_valid !== 1'b0 || flit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: got valid=%b ready=%b required valid=0 ready=1", name, pkt_valid, flit_ready);
    end
    #1;
    vectors++;
    if (err_cnt !== m_err) begin
      miscompares++;
      $display("FAIL %s err_count: got %0d required %0d", name, err_cnt, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 1; flit_valid = 0; flit_label = HEAD; flit_payload = 0;
    pkt_ack = 0; pkt_rd_idx = 0; local_x = 2'd1; local_y = 2'd2;
    repeat (2) @(negedge clk);
    vectors++;
    if (flit_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_during: got %b required 0", flit_ready);
    end
    rst = 0;
    @(negedge clk);
    vectors++;
    if (flit_ready !== 1'b1 || pkt_valid !== 1'b0 || err_unexpected !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b err=%b required 1 0 0", flit_ready, pkt_valid, err_unexpected);
    end
    vectors++;
    if ({pkt_x, pkt_y, pkt_head, pkt_len, pkt_misroute, pkt_trunc} !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: got x=%0d y=%0d h=%h len=%0d mis=%b trunc=%b required all 0",
               pkt_x, pkt_y, pkt_head, pkt_len, pkt_misroute, pkt_trunc);
    end
    m_open = 0; m_done = 0;
  endtask

  task automatic test_basic();
    local_x = 1; local_y = 2;
    send_flit(HEAD, mk_head(2'd1, 2'd2, 12'hABC));
    send_flit(BODY, 16'h1111);
    send_flit(BODY, 16'h2222);
    vectors++;
    if (pkt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid: got %b required 0", pkt_valid);
    end
    send_flit(TAIL, 16'h3333);
    vectors++;
    if (pkt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: got %b required 1", pkt_valid);
    end
    receive_packet("basic");
  endtask

  task automatic test_headtail_misroute();
    local_x = 1; local_y = 2;
    send_flit(HEADTAIL, mk_head(2'd3, 2'd0, 12'h005));
    receive_packet("headtail_misroute");
  endtask

  task automatic test_trunc();
    send_flit(HEAD, mk_head(2'd1, 2'd2, 12'h123));
    for (int i = 0; i < 10; i++) send_flit(BODY, 16'(i));
    send_flit(TAIL, 16'hA);
    receive_packet("trunc");
  endtask

  task automatic test_unexpected();
    int e0 = err_cnt;
    send_flit(BODY, 16'h5555);
    @(negedge clk);
    #1;
    vectors++;
    if (err_cnt !== e0 + 1 || pkt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_body: got errs=%0d valid=%b required errs=%0d valid=0", err_cnt - e0, pkt_valid, 1);
    end
    @(negedge clk);
    send_flit(HEAD, mk_head(2'd1, 2'd2, 12'h0AA));
    send_flit(BODY, 16'h0001);
    send_flit(HEAD, mk_head(2'd1, 2'd2, 12'h077));
    send_flit(TAIL, 16'h0009);
    receive_packet("restart");
    vectors++;
    if (err_cnt !== e0 + 2) begin
      miscompares++;
      $display("FAIL restart_err_total: got %0d required 2", err_cnt - e0);
    end
  endtask

  task automatic test_hold_backpressure();
    send_flit(HEAD, mk_head(2'd1, 2'd2, 12'h456));
    send_flit(TAIL, 16'hBEEF);
    flit_valid = 1; flit_label = HEAD; flit_payload = mk_head(2'd0, 2'd1, 12'h321);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (flit_ready !== 1'b0 || pkt_valid !== 1'b1 || pkt_head !== 12'h456 || pkt_len !== 4'd1) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got ready=%b valid=%b h=%h len=%0d required 0 1 456 1",
                 i, flit_ready, pkt_valid, pkt_head, pkt_len);
      end
      @(negedge clk);
    end
    pkt_rd_idx = 0;
    #1;
    vectors++;
    if (pkt_rd_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL hold_word: got %h required beef", pkt_rd_data);
    end
    @(negedge clk);
    pkt_ack = 1;
    vectors++;
    if (flit_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ack_bypass: got ready=%b required 0", flit_ready);
    end
    @(negedge clk);
    pkt_ack = 0;
    m_done = 0;
    vectors++;
    if (flit_ready !== 1'b1 || pkt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got ready=%b valid=%b required 1 0", flit_ready, pkt_valid);
    end
    model_apply(HEAD, flit_payload);
    @(negedge clk);
    send_flit(TAIL, 16'h7777);
    receive_packet("after_hold");
  endtask

  task automatic test_mid_reset();
    send_flit(HEAD, mk_head(2'd1, 2'd2, 12'hFFF));
    send_flit(BODY, 16'hAAAA);
    send_flit(BODY, 16'hBBBB);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_open = 0; m_done = 0;
    @(negedge clk);
    vectors++;
    if (pkt_valid !== 1'b0 || flit_ready !== 1'b1 || pkt_len !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b ready=%b len=%0d required 0 1 0", pkt_valid, flit_ready, pkt_len);
    end
    send_flit(HEADTAIL, mk_head(2'd1, 2'd2, 12'h0C0));
    receive_packet("post_reset");
  endtask

  task automatic test_random();
    for (int p = 0; p < 40; p++) begin
      local_x = 2'($urandom_range(0, 3));
      local_y = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) send_flit(BODY, 16'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        send_flit(HEAD, 16'($urandom));
        repeat ($urandom_range(0, 3)) send_flit(BODY, 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        send_flit(HEADTAIL, 16'($urandom));
      end else begin
        send_flit(HEAD, 16'($urandom));
        for (int b = $urandom_range(0, 10); b > 0; b--) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send_flit(BODY, 16'($urandom));
        end
        send_flit(TAIL, 16'($urandom));
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      receive_packet($sformatf("random%0d", p));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_headtail_misroute();
    test_trunc();
    test_unexpected();
    test_hold_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flit_depacketizer.md
Name: flit_depacketizer

Overview:
- Receive-side counterpart of the flit builder: consumes a no-VC flit stream (HEAD, BODY*, TAIL, or single HEADTAIL) from the router local port and reassembles one packet at a time.
- Holds the decoded head fields and up to BUFFER_SIZE body words in an internal buffer.
- Presents the completed packet to the network interface consumer until it is acknowledged.
- Flags protocol errors and packets delivered to the wrong node.

Parameters:
- BUFFER_SIZE, 8: maximum body/tail words stored per packet.
- X_W, 2: x destination field width.
- Y_W, 2: y destination field width.
- HP_W, 12: head payload width.
- DATA_W, 16: flit payload width. Must satisfy X_W+Y_W+HP_W <= DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- local_x  in  X_W  this node's x coordinate.
- local_y  in  Y_W  this node's y coordinate.
- flit_valid  in  1  flit present.
- flit_ready  out  1  block accepts flit this cycle.
- flit_label  in  2  flit type: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
- flit_payload  in  DATA_W  flit data.
- pkt_valid  out  1  completed packet available.
- pkt_ack  in  1  consumer releases packet (single-cycle pulse).
- pkt_x  out  X_W  head x_Dest.
- pkt_y  out  Y_W  head y_Dest.
- pkt_head  out  HP_W  head payload.
- pkt_len  out  $clog2(BUFFER_SIZE+1)  number of stored body words.
- pkt_misroute  out  1  head destination != (local_x, local_y).
- pkt_trunc  out  1  body words were dropped because the buffer was full.
- pkt_rd_idx  in  $clog2(BUFFER_SIZE)  body word select.
- pkt_rd_data  out  DATA_W  combinational read of body word at pkt_rd_idx.
- err_unexpected  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Transfer occurs when flit_valid && flit_ready.
- HEAD field layout in flit_payload:
  - x = [X_W-1:0]
  - y = [X_W+Y_W-1:X_W]
  - head = [X_W+Y_W+HP_W-1:X_W+Y_W]
- BODY and TAIL: the whole flit_payload is one body word.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE, flit_ready=1:
    - HEAD: latch fields, len=0, trunc=0, go to COLLECT.
    - HEADTAIL: latch fields, len=0, go to HOLD.
    - BODY/TAIL: flit dropped, err_unexpected pulses, stay in IDLE.
  - COLLECT, flit_ready=1:
    - BODY: store at buffer[len], len+1.
    - TAIL: store the word as for BODY, then go to HOLD.
    - HEAD: abandon the partial packet, err_unexpected pulses, restart collection with the new head fields (len=0, trunc=0), stay in COLLECT.
    - HEADTAIL: abandon the partial packet, err pulses, latch the new head, go to HOLD.
  - HOLD:
    - flit_ready=0 and pkt_valid=1; all pkt_* outputs stable.
    - pkt_ack: go to IDLE next cycle with pkt_valid=0. flit_ready returns to 1 the cycle after the ack; there is no same-cycle bypass.
    - pkt_ack in any other state is ignored.
- Buffer full (len==BUFFER_SIZE):
  - Further BODY words are accepted and dropped; trunc is set; len saturates.
  - A TAIL at full is dropped, sets trunc, and still completes the packet (go to HOLD).
- pkt_misroute is computed from the latched head against local_x/local_y at head acceptance, then held.
- Latency: pkt_valid rises the cycle after the TAIL/HEADTAIL transfer.
- pkt_rd_data for pkt_rd_idx >= pkt_len is don't-care.
- pkt_* outputs are only meaningful while pkt_valid=1.
- Reset (sync, also mid-packet or in HOLD):
  - State=IDLE, pkt_valid=0, flit_ready=1 the cycle after reset deasserts.
  - err_unexpected=0; pkt_x/pkt_y/pkt_head/pkt_len/pkt_misroute/pkt_trunc=0.
  - Buffer contents not reset.
  - flit_ready is 0 while rst=1.

Test Plan:
- local=(1,2). HEAD{x=1, y=2, head=0xABC}, BODY 0x1111, BODY 0x2222, TAIL 0x3333 back-to-back → pkt_valid the cycle after TAIL, len=3, rd_data[0..2]=0x1111/0x2222/0x3333, misroute=0, trunc=0; pkt_ack → flit_ready=1 next cycle.
- HEADTAIL{x=3, y=0, head=0x005} with local=(1,2) → pkt_valid, len=0, misroute=1, head=0x005.
- BUFFER_SIZE=8: HEAD, 10 BODY (0x0..0x9), TAIL 0xA → len=8, words 0x0..0x7, trunc=1, err_unexpected never pulses.
- In IDLE: BODY 0x5555 → err_unexpected pulses once, no pkt_valid. Then HEAD, BODY 0x1, HEAD{head=0x077}, TAIL 0x9 → second err pulse, packet head=0x077, len=1, word0=0x9.
- Packet in HOLD, flit_valid held high with a HEAD → flit_ready=0 and no acceptance until the cycle after pkt_ack; outputs unchanged throughout.
- Assert rst for 1 cycle after HEAD + 2 BODY → pkt_valid=0, IDLE; a following HEADTAIL produces a clean packet with len=0, trunc=0.
